// File: rtl/virtual_chip_pkg.sv
// rtl/virtual_chip_pkg.sv - opcode, flag and command-field definitions for virtual_chip
package virtual_chip_pkg;

   typedef enum logic [3:0] {
      OP_PASS   = 4'h0,
      OP_ADD    = 4'h1,
      OP_SUB    = 4'h2,
      OP_AND    = 4'h3,
      OP_OR     = 4'h4,
      OP_XOR    = 4'h5,
      OP_NOT    = 4'h6,
      OP_SHL    = 4'h7,
      OP_SHR    = 4'h8,
      OP_ROL    = 4'h9,
      OP_ACCADD = 4'hA,
      OP_ACCSUB = 4'hB,
      OP_MUL    = 4'hC,
      OP_CMP    = 4'hD,
      OP_SWAP   = 4'hE,
      OP_REV    = 4'hF
   } op_t;

   // Bit indices into the MSB-first [0:7] buses
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_P = 7;

   localparam int CMD_EXEC = 1;
   localparam int CMD_WB   = 2;

endpackage

// File: rtl/virtual_chip_alu.sv
// rtl/virtual_chip_alu.sv - combinational ALU computing result and flags for virtual_chip
// Parity flag on bit 7 is produced only when VCHIP_PARITY_EN is defined.
module virtual_chip_alu
   import virtual_chip_pkg::*;
(
   input  op_t        op_i,
   input  logic [7:0] b_i,
   input  logic [7:0] c_i,
   input  logic [7:0] acc_i,
   output logic [0:7] result_o,
   output logic [0:7] flags_o
);

   logic [8:0]  sum9;
   logic [7:0]  res;
   logic [15:0] rot;
   logic [15:0] prod;
   logic [2:0]  sh;
   logic        carry;
   logic        ovf;

   assign sh   = c_i[2:0];
   assign rot  = {b_i, b_i} << sh;
   assign prod = b_i * c_i;

   always_comb begin
      sum9  = 9'd0;
      res   = 8'd0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op_i)
         OP_PASS: res = b_i;
         OP_ADD: begin
            sum9  = {1'b0, b_i} + {1'b0, c_i};
            res   = sum9[7:0];
            carry = sum9[8];
            ovf   = (b_i[7] == c_i[7]) && (res[7] != b_i[7]);
         end
         OP_SUB: begin
            res   = b_i - c_i;
            carry = b_i < c_i;
            ovf   = (b_i[7] != c_i[7]) && (res[7] != b_i[7]);
         end
         OP_AND:  res = b_i & c_i;
         OP_OR:   res = b_i | c_i;
         OP_XOR:  res = b_i ^ c_i;
         OP_NOT:  res = ~b_i;
         OP_SHL:  res = b_i << sh;
         OP_SHR:  res = b_i >> sh;
         OP_ROL:  res = rot[15:8];
         OP_ACCADD: begin
            sum9  = {1'b0, acc_i} + {1'b0, b_i};
            res   = sum9[7:0];
            carry = sum9[8];
            ovf   = (acc_i[7] == b_i[7]) && (res[7] != acc_i[7]);
         end
         OP_ACCSUB: begin
            res   = acc_i - b_i;
            carry = acc_i < b_i;
            ovf   = (acc_i[7] != b_i[7]) && (res[7] != acc_i[7]);
         end
         OP_MUL:  res = prod[7:0];
         OP_CMP:  res = (b_i > c_i) ? 8'h01 : 8'h00;
         OP_SWAP: res = {b_i[3:0], b_i[7:4]};
         OP_REV: begin
            for (int i = 0; i < 8; i++) res[i] = b_i[7-i];
         end
         default: res = b_i;
      endcase
   end

   always_comb begin
      flags_o         = 8'h00;
      flags_o[FLAG_Z] = (res == 8'h00);
      flags_o[FLAG_C] = carry;
      flags_o[FLAG_N] = res[7];
      flags_o[FLAG_V] = ovf;
`ifdef VCHIP_PARITY_EN
      flags_o[FLAG_P] = ^res;
`else
      flags_o[FLAG_P] = 1'b0;
`endif
   end

   assign result_o = res;

endmodule

// File: rtl/virtual_chip.sv
// rtl/virtual_chip.sv - virtual_chip top: output/accumulator registers with EXEC/WB gating
// Optional parity flag controlled by VCHIP_PARITY_EN (see virtual_chip_alu).
module virtual_chip
   import virtual_chip_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:7] ain,
   input  logic [0:7] bin,
   input  logic [0:7] cin,
   output logic [0:7] aout,
   output logic [0:7] bout,
   output logic [0:7] cout
);

   logic [0:7] aout_q, aout_d;
   logic [0:7] bout_q, bout_d;
   logic [0:7] acc_q, acc_d;
   logic [0:7] alu_result;
   logic [0:7] alu_flags;
   logic       unused_reserved;

   assign unused_reserved = ain[0] ^ ain[3];

   virtual_chip_alu u_alu (
      .op_i     (op_t'(ain[4:7])),
      .b_i      (bin),
      .c_i      (cin),
      .acc_i    (acc_q),
      .result_o (alu_result),
      .flags_o  (alu_flags)
   );

   always_comb begin
      aout_d = aout_q;
      bout_d = bout_q;
      acc_d  = acc_q;
      if (ain[CMD_EXEC]) begin
         aout_d = alu_result;
         bout_d = alu_flags;
         if (ain[CMD_WB]) acc_d = alu_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aout_q <= 8'h00;
         bout_q <= 8'h00;
         acc_q  <= 8'h00;
      end else begin
         aout_q <= aout_d;
         bout_q <= bout_d;
         acc_q  <= acc_d;
      end
   end

   assign aout = aout_q;
   assign bout = bout_q;
   assign cout = acc_q;

endmodule

// File: tb/tb_virtual_chip.sv
// tb/tb_virtual_chip.sv - directed self-checking bench for virtual_chip
module tb_virtual_chip;

   logic       clk;
   logic       rst_n;
   logic [0:7] ain, bin, cin;
   logic [0:7] aout, bout, cout;
   int         n_cmp;
   int         n_bad;

   virtual_chip dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ain   (ain),
      .bin   (bin),
      .cin   (cin),
      .aout  (aout),
      .bout  (bout),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] with_par(input logic [7:0] flags, input logic [7:0] res);
`ifdef VCHIP_PARITY_EN
      return flags | {7'b0, ^res};
`else
      return flags | (8'h00 & {7'b0, ^res});
`endif
   endfunction

   task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] ec);
      @(negedge clk);
      ain = a; bin = b; cin = c;
      @(posedge clk);
      #1;
      chk({tag, ".aout"}, aout, ea);
      chk({tag, ".bout"}, bout, with_par(eb, ea));
      chk({tag, ".cout"}, cout, ec);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      ain = 8'h00; bin = 8'h00; cin = 8'h00;
      #12;
      chk("por.aout", aout, 8'h00);
      chk("por.bout", bout, 8'h00);
      chk("por.cout", cout, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // load non-zero state, then assert reset mid-cycle
      apply("pre", 8'h61, 8'h05, 8'h03, 8'h08, 8'h00, 8'h08);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.aout", aout, 8'h00);
      chk("arst.bout", bout, 8'h00);
      chk("arst.cout", cout, 8'h00);
      ain = 8'h61; bin = 8'h05; cin = 8'h03;
      @(posedge clk);
      #1;
      chk("hold_rst.aout", aout, 8'h00);
      chk("hold_rst.cout", cout, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      apply("pass0",  8'h60, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00);
      apply("noexec", 8'h28, 8'h3C, 8'h02, 8'h00, 8'h80, 8'h00);
      apply("sub_wb", 8'h62, 8'h70, 8'h02, 8'h6E, 8'h00, 8'h6E);
      apply("add_wb", 8'h61, 8'h28, 8'hA9, 8'hD1, 8'h20, 8'hD1);
      apply("not_wb", 8'h66, 8'h20, 8'h00, 8'hDF, 8'h20, 8'hDF);
      apply("add_ff", 8'h41, 8'hFF, 8'h01, 8'h00, 8'hC0, 8'hDF);
      apply("add_7f", 8'h41, 8'h7F, 8'h01, 8'h80, 8'h30, 8'hDF);
      apply("accadd", 8'h6A, 8'h31, 8'h00, 8'h10, 8'h40, 8'h10);
      apply("accsub", 8'h6B, 8'h20, 8'h00, 8'hF0, 8'h60, 8'hF0);
      apply("sub_v",  8'h42, 8'h80, 8'h01, 8'h7F, 8'h10, 8'hF0);
      apply("shl",    8'h47, 8'h81, 8'h03, 8'h08, 8'h00, 8'hF0);
      apply("shr",    8'h48, 8'h81, 8'hF9, 8'h40, 8'h00, 8'hF0);
      apply("rol",    8'h49, 8'h81, 8'h01, 8'h03, 8'h00, 8'hF0);
      apply("rol0",   8'h49, 8'h81, 8'h08, 8'h81, 8'h20, 8'hF0);
      apply("mul",    8'h4C, 8'h10, 8'h11, 8'h10, 8'h00, 8'hF0);
      apply("cmp_gt", 8'h4D, 8'h05, 8'h04, 8'h01, 8'h00, 8'hF0);
      apply("cmp_eq", 8'h4D, 8'h05, 8'h05, 8'h00, 8'h80, 8'hF0);
      apply("swap",   8'h4E, 8'h3C, 8'h00, 8'hC3, 8'h20, 8'hF0);
      apply("rev",    8'h4F, 8'h01, 8'h00, 8'h80, 8'h20, 8'hF0);
      apply("rsvd",   8'hD3, 8'hF0, 8'h3C, 8'h30, 8'h00, 8'hF0);
      apply("or_wb",  8'h64, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h0F);
      apply("xor",    8'h45, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h0F);
      apply("pass7",  8'h40, 8'h07, 8'h00, 8'h07, 8'h00, 8'h0F);
      apply("wb_noex",8'h26, 8'h55, 8'h00, 8'h07, 8'h00, 8'h0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/virtual_chip.md
Name: virtual_chip

Overview:
- Synthetic 8-bit "device under test" used to exercise the chip-tester datapath.
- Three 8-bit input buses in, three registered 8-bit output buses out.
- ain is a command byte; bin and cin are operands.
- Outputs are aout = result, bout = status flags, cout = accumulator; all update one clock after a command is presented.

Parameters:
- None. Widths are fixed at 8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ain  in  [0:7]  command byte; bit 0 is MSB on all buses
- bin  in  [0:7]  operand B
- cin  in  [0:7]  operand C
- aout  out  [0:7]  registered result
- bout  out  [0:7]  registered flags: [0]=Z, [1]=C, [2]=N, [3]=V, [4:7]=0 (see optional feature)
- cout  out  [0:7]  registered accumulator ACC

Behaviour:
- Reset (rst_n=0, asynchronous): aout, bout and ACC (cout) all 0x00, held until rst_n rises. Reset mid-operation discards any pending command.
- Command fields:
  - ain[4:7] = opcode
  - ain[1] = EXEC
  - ain[2] = WB (write result to ACC)
  - ain[0] and ain[3] are reserved and ignored.
- Every rising edge with EXEC=1: aout <= result; bout <= flags; if WB=1, ACC <= result.
- EXEC=0: all outputs hold; WB is ignored.
- Latency is 1 cycle. Inputs are sampled every edge; there is no handshake.
- All arithmetic is unsigned mod 256 unless stated otherwise. B=bin, C=cin.
- Opcodes:
  - 0 PASS: B
  - 1 ADD: B+C
  - 2 SUB: B-C
  - 3 AND: B&C
  - 4 OR: B|C
  - 5 XOR: B^C
  - 6 NOT: ~B
  - 7 SHL: B<<C[5:7]
  - 8 SHR: B>>C[5:7], logical
  - 9 ROL: B rotate-left by C[5:7]
  - A ACCADD: ACC+B
  - B ACCSUB: ACC-B
  - C MUL: low byte of B*C
  - D CMP: 0x01 if B>C unsigned, else 0x00
  - E SWAP: nibble swap of B
  - F REV: bit-reverse of B
- Flags:
  - Z = (result==0)
  - N = result[0]
  - C = carry-out for ADD/ACCADD; borrow (minuend<subtrahend) for SUB/ACCSUB; 0 otherwise.
  - V = signed two's-complement overflow for ADD/SUB/ACCADD/ACCSUB; 0 otherwise.
- Shift amount 0 returns B unchanged for SHL/SHR/ROL.
- ACC-sourced ops use the ACC value from before the edge. WB with the same op updates ACC to the new result.

Optional Feature:
- VCHIP_PARITY_EN
  - Defined: bout[7] = XOR-reduction of the result (even-parity bit), registered with the other flags.
  - Undefined: bout[7] = 0.
- bout[4:6] are always 0.

Decomposition:
- Package virtual_chip_pkg holds:
  - opcode enum (OP_PASS..OP_REV)
  - flag bit-index constants (FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3, FLAG_P=7)
  - command field index constants (CMD_EXEC=1, CMD_WB=2)
- Sub-module virtual_chip_alu: purely combinational; takes opcode, B, C and ACC; produces result and flags.
- Top level holds only the registers and the EXEC/WB gating.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> aout=bout=cout=0x00 immediately; remain 0 until release.
- ain=0x60, bin=0x00, cin=0x00 -> next edge: aout=0x00, bout=0x80 (Z), cout=0x00.
- ain=0x28, bin=0x3C, cin=0x02 (EXEC=0) -> outputs hold 0x00/0x80/0x00.
- ain=0x62, bin=0x70, cin=0x02 (SUB, WB) -> aout=0x6E, bout=0x00, cout=0x6E.
- ain=0x61, bin=0x28, cin=0xA9 (ADD, WB) -> aout=0xD1, bout=0x20 (N), cout=0xD1. Then ain=0x66, bin=0x20 (NOT, WB) -> aout=0xDF, bout=0x20, cout=0xDF.
- Boundaries:
  - ADD 0xFF+0x01 -> aout=0x00, bout=0xC0 (Z,C).
  - ADD 0x7F+0x01 -> aout=0x80, bout=0x30 (N,V).
  - With VCHIP_PARITY_EN, PASS 0x07 -> bout[7]=1.
